// File: rtl/plru_victim_fill_ctrl.sv
// Miss handler downstream of the 16-way pseudo-LRU: victim select, writeback, line fill, LRU update.
// Optional miss statistics counters are built when PLRU_MISS_STATS_EN is defined.
module plru_victim_fill_ctrl #(
  parameter int TAG_W = 9,
  parameter int SET_W = 3,
  parameter int OFF_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [SET_W-1:0]             req_set,
  input  logic [TAG_W-1:0]             req_tag,
  input  logic [3:0]                   lru_way,
  input  logic [15:0]                  way_valid,
  input  logic [15:0]                  way_dirty,
  output logic [3:0]                   way_sel,
  input  logic [TAG_W-1:0]             sel_tag,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [TAG_W+SET_W+OFF_W-1:0] mem_addr,
  input  logic                         mem_resp,
  output logic                         fill_we,
  output logic [SET_W-1:0]             fill_set,
  output logic [3:0]                   fill_way,
  output logic [TAG_W-1:0]             fill_tag,
  output logic                         lru_load,
  output logic [3:0]                   lru_hit,
  output logic                         done,
  output logic [15:0]                  wb_count,
  output logic [15:0]                  fill_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    WB     = 3'd2,
    FILL   = 3'd3,
    UPDATE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [SET_W-1:0]   set_q;
  logic [TAG_W-1:0]   tag_q;
  logic [TAG_W-1:0]   vtag_q;
  logic [3:0]         vway_q;
  logic               dirty_q;
  logic [3:0]         victim;
  logic               victim_dirty;

  // Lowest invalid way wins; scanning downward lets the lowest index overwrite.
  always_comb begin
    victim = lru_way;
    for (int i = 15; i >= 0; i--) begin
      if (!way_valid[i]) victim = 4'(i);
    end
    victim_dirty = way_valid[victim] & way_dirty[victim];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      set_q   <= '0;
      tag_q   <= '0;
      vtag_q  <= '0;
      vway_q  <= '0;
      dirty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        set_q <= req_set;
        tag_q <= req_tag;
      end
      if (state_q == SELECT) begin
        vway_q  <= victim;
        vtag_q  <= sel_tag;
        dirty_q <= victim_dirty;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    way_sel   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    fill_we   = 1'b0;
    fill_set  = '0;
    fill_way  = '0;
    fill_tag  = '0;
    lru_load  = 1'b0;
    lru_hit   = '0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = SELECT;
      end
      SELECT: begin
        way_sel = victim;
        state_d = victim_dirty ? WB : FILL;
      end
      WB: begin
        mem_write = dirty_q;
        mem_addr  = {vtag_q, set_q, {OFF_W{1'b0}}};
        if (mem_resp) state_d = FILL;
      end
      FILL: begin
        mem_read = 1'b1;
        mem_addr = {tag_q, set_q, {OFF_W{1'b0}}};
        if (mem_resp) state_d = UPDATE;
      end
      UPDATE: begin
        fill_we  = 1'b1;
        fill_set = set_q;
        fill_way = vway_q;
        fill_tag = tag_q;
        lru_load = 1'b1;
        lru_hit  = vway_q;
        done     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PLRU_MISS_STATS_EN
  logic [15:0] wb_cnt_q, fill_cnt_q;

  // Saturating counts of memory completions seen in each memory phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_cnt_q   <= '0;
      fill_cnt_q <= '0;
    end else begin
      if (state_q == WB && mem_resp && wb_cnt_q != 16'hFFFF)
        wb_cnt_q <= wb_cnt_q + 16'd1;
      if (state_q == FILL && mem_resp && fill_cnt_q != 16'hFFFF)
        fill_cnt_q <= fill_cnt_q + 16'd1;
    end
  end

  assign wb_count   = wb_cnt_q;
  assign fill_count = fill_cnt_q;
`else
  assign wb_count   = '0;
  assign fill_count = '0;
`endif

endmodule

// File: tb/tb_plru_victim_fill_ctrl.sv
// Self-checking bench for plru_victim_fill_ctrl: directed table, reset abort and random misses
// checked against a transaction-level model of victim choice, addresses and latency.
module tb_plru_victim_fill_ctrl;

  localparam int TAG_W  = 9;
  localparam int SET_W  = 3;
  localparam int OFF_W  = 4;
  localparam int ADDR_W = TAG_W + SET_W + OFF_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic [SET_W-1:0]   req_set;
  logic [TAG_W-1:0]   req_tag;
  logic [3:0]         lru_way;
  logic [15:0]        way_valid;
  logic [15:0]        way_dirty;
  logic [3:0]         way_sel;
  logic [TAG_W-1:0]   sel_tag;
  logic               mem_read;
  logic               mem_write;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_resp;
  logic               fill_we;
  logic [SET_W-1:0]   fill_set;
  logic [3:0]         fill_way;
  logic [TAG_W-1:0]   fill_tag;
  logic               lru_load;
  logic [3:0]         lru_hit;
  logic               done;
  logic [15:0]        wb_count;
  logic [15:0]        fill_count;

  logic [TAG_W-1:0]   tag_mem [16];
  int                 checks = 0;
  int                 failures = 0;
  int                 exp_wb_total = 0;
  int                 exp_fill_total = 0;

  typedef struct {
    logic [15:0]      valid;
    logic [15:0]      dirty;
    logic [3:0]       lru;
    logic [SET_W-1:0] set;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] vtag;
    int               wait_cyc;
    logic [3:0]       exp_way;
    bit               exp_dirty;
    int               exp_lat;
  } vec_t;

  always #5 clk = ~clk;

  // The tag array answers the way_sel read combinationally.
  assign sel_tag = tag_mem[way_sel];

  plru_victim_fill_ctrl #(.TAG_W(TAG_W), .SET_W(SET_W), .OFF_W(OFF_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_set(req_set), .req_tag(req_tag), .lru_way(lru_way), .way_valid(way_valid),
    .way_dirty(way_dirty), .way_sel(way_sel), .sel_tag(sel_tag), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_resp(mem_resp), .fill_we(fill_we),
    .fill_set(fill_set), .fill_way(fill_way), .fill_tag(fill_tag), .lru_load(lru_load),
    .lru_hit(lru_hit), .done(done), .wb_count(wb_count), .fill_count(fill_count)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Victim = lowest zero bit of way_valid (isolated arithmetically), else the LRU way.
  function automatic logic [3:0] model_victim(input logic [15:0] valid, input logic [3:0] lru);
    logic [16:0] lowest_zero;
    if (&valid) return lru;
    lowest_zero = {1'b0, ~valid} & ({1'b0, valid} + 17'd1);
    return 4'($clog2(lowest_zero));
  endfunction

  function automatic vec_t model_vec(input vec_t v);
    vec_t r;
    r = v;
    r.exp_way   = model_victim(v.valid, v.lru);
    r.exp_dirty = v.valid[r.exp_way] & v.dirty[r.exp_way];
    r.exp_lat   = 2 + (v.wait_cyc + 1) + (r.exp_dirty ? v.wait_cyc + 1 : 0);
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_ready"}, 32'(req_ready), 32'd1);
    check_output({tag, "_strobes"}, 32'({mem_read, mem_write, fill_we, lru_load, done}), 32'd0);
    check_output({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check_output({tag, "_fill"}, 32'({fill_set, fill_way, fill_tag, lru_hit}), 32'd0);
  endtask

  // One complete miss, starting from the first IDLE cycle; a memory model replies after wait_cyc stalls.
  task automatic apply_stimulus(input vec_t v);
    int wb_cyc, rd_cyc, loads, done_cyc;
    bit saw_done;
    logic [ADDR_W-1:0] wb_addr, rd_addr;
    wb_addr  = {v.vtag, v.set, {OFF_W{1'b0}}};
    rd_addr  = {v.tag, v.set, {OFF_W{1'b0}}};
    wb_cyc   = 0;
    rd_cyc   = 0;
    loads    = 0;
    done_cyc = 0;
    saw_done = 0;
    @(negedge clk);
    mem_resp = 1'b0;
    check_output("accept_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 16; k++) tag_mem[k] = TAG_W'($urandom);
    tag_mem[v.exp_way] = v.vtag;
    way_valid = v.valid;
    way_dirty = v.dirty;
    lru_way   = v.lru;
    req_set   = v.set;
    req_tag   = v.tag;
    req_valid = 1'b1;
    for (int cyc = 1; cyc <= 60 && !saw_done; cyc++) begin
      @(negedge clk);
      req_valid = 1'($urandom);
      req_set   = SET_W'($urandom);
      req_tag   = TAG_W'($urandom);
      mem_resp  = 1'b0;
      if (cyc >= 2) begin
        way_valid = 16'($urandom);
        way_dirty = 16'($urandom);
        lru_way   = 4'($urandom);
      end
      if (cyc == 1) begin
        check_output("select_ready", 32'(req_ready), 32'd0);
        check_output("select_way_sel", 32'(way_sel), 32'(v.exp_way));
        mem_resp = 1'b1;
      end
      if (mem_read && mem_write) check_output("rd_wr_exclusive", 32'd1, 32'd0);
      if (mem_write) begin
        wb_cyc++;
        check_output("wb_addr", 32'(mem_addr), 32'(wb_addr));
        check_output("wb_before_read", 32'(rd_cyc), 32'd0);
        if (wb_cyc == v.wait_cyc + 1) mem_resp = 1'b1;
      end
      if (mem_read) begin
        rd_cyc++;
        check_output("rd_addr", 32'(mem_addr), 32'(rd_addr));
        if (rd_cyc == v.wait_cyc + 1) mem_resp = 1'b1;
      end
      if (lru_load) loads++;
      if (done) begin
        saw_done = 1;
        done_cyc = cyc;
        check_output("upd_fill_we", 32'(fill_we), 32'd1);
        check_output("upd_fill_way", 32'(fill_way), 32'(v.exp_way));
        check_output("upd_lru_hit", 32'(lru_hit), 32'(v.exp_way));
        check_output("upd_fill_tag", 32'(fill_tag), 32'(v.tag));
        check_output("upd_fill_set", 32'(fill_set), 32'(v.set));
        check_output("upd_ready", 32'(req_ready), 32'd0);
        mem_resp = 1'b1;
      end
    end
    req_valid = 1'b0;
    check_output("done_seen", 32'(saw_done), 32'd1);
    check_output("latency", 32'(done_cyc), 32'(v.exp_lat));
    check_output("wb_cycles", 32'(wb_cyc), v.exp_dirty ? 32'(v.wait_cyc + 1) : 32'd0);
    check_output("rd_cycles", 32'(rd_cyc), 32'(v.wait_cyc + 1));
    check_output("lru_load_once", 32'(loads), 32'd1);
    if (v.exp_dirty) exp_wb_total++;
    exp_fill_total++;
  endtask

  vec_t tbl [8];
  vec_t rv;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_set = '0; req_tag = '0; lru_way = '0;
    way_valid = '0; way_dirty = '0; mem_resp = 1'b0;
    for (int k = 0; k < 16; k++) tag_mem[k] = '0;

    tbl[0] = '{16'hFFDF, 16'h0000, 4'd9,  3'd2, 9'h1A3, 9'h0AA, 0, 4'd5,  1'b0, 3};
    tbl[1] = '{16'hFFFF, 16'h0800, 4'd11, 3'd5, 9'h13C, 9'h055, 0, 4'd11, 1'b1, 4};
    tbl[2] = '{16'hFFFF, 16'h0000, 4'd0,  3'd7, 9'h0F0, 9'h011, 0, 4'd0,  1'b0, 3};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 4'd6,  3'd1, 9'h1FF, 9'h123, 7, 4'd6,  1'b1, 18};
    tbl[4] = '{16'h7FFF, 16'h8000, 4'd3,  3'd0, 9'h000, 9'h1F0, 1, 4'd15, 1'b0, 4};
    tbl[5] = '{16'h0000, 16'hFFFF, 4'd12, 3'd6, 9'h0C5, 9'h099, 2, 4'd0,  1'b0, 5};
    tbl[6] = '{16'hFFFF, 16'h7FFF, 4'd15, 3'd3, 9'h15A, 9'h0E1, 0, 4'd15, 1'b0, 3};
    tbl[7] = '{16'hEFFF, 16'h1000, 4'd2,  3'd4, 9'h066, 9'h177, 0, 4'd12, 1'b0, 3};

    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    for (int i = 0; i < 8; i++) apply_stimulus(tbl[i]);

    // Reset during FILL must abandon the miss with no fill or LRU update.
    @(negedge clk);
    mem_resp = 1'b0; way_valid = 16'hFFFF; way_dirty = '0; lru_way = 4'd3;
    req_set = 3'd4; req_tag = 9'h0C3; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check_output("abort_select_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check_output("abort_fill_read", 32'(mem_read), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("abort_reset");
    check_output("abort_way_sel", 32'(way_sel), 32'd0);
    mem_resp = 1'b1;
    exp_wb_total = 0;
    exp_fill_total = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_output("abort_no_fill", 32'({fill_we, lru_load, done}), 32'd0);
      check_output("abort_ready", 32'(req_ready), 32'd1);
    end
    mem_resp = 1'b0;

    for (int i = 0; i < 24; i++) begin
      rv.valid    = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
      rv.dirty    = 16'($urandom);
      rv.lru      = 4'($urandom);
      rv.set      = SET_W'($urandom);
      rv.tag      = TAG_W'($urandom);
      rv.vtag     = TAG_W'($urandom);
      rv.wait_cyc = $urandom_range(0, 3);
      apply_stimulus(model_vec(rv));
    end

    @(negedge clk);
`ifdef PLRU_MISS_STATS_EN
    check_output("stat_wb_count", 32'(wb_count), 32'(exp_wb_total));
    check_output("stat_fill_count", 32'(fill_count), 32'(exp_fill_total));
`else
    check_output("stat_wb_tied", 32'(wb_count), 32'd0);
    check_output("stat_fill_tied", 32'(fill_count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
